// File: rtl/xs3_pkg.sv
// Shared definitions for the Excess-3 to BCD sequencer: FSM states,
// code-range constants and a digit validity helper.
package xs3_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Lowest and highest legal Excess-3 digit codes
    localparam logic [3:0] XS3_MIN = 4'h3;
    localparam logic [3:0] XS3_MAX = 4'hC;

    // Marker written into a BCD digit whose source code was illegal
    localparam logic [3:0] BCD_ERR = 4'hF;

    // True when the 4-bit code is a legal Excess-3 digit
    function automatic logic xs3_is_valid(input logic [3:0] code);
        return (code >= XS3_MIN) && (code <= XS3_MAX);
    endfunction

endpackage

// File: rtl/xs3_digit_conv.sv
// Single-digit Excess-3 to BCD converter (purely combinational).
// Legal codes map to code-3; illegal codes produce BCD_ERR and raise err.
module xs3_digit_conv
    import xs3_pkg::*;
(
    input  logic [3:0] xs3,
    output logic [3:0] bcd,
    output logic       err
);

    // Range check and subtract-3 for one digit
    always_comb begin
        err = !xs3_is_valid(xs3);
        bcd = err ? BCD_ERR : (xs3 - XS3_MIN);
    end

endmodule

// File: rtl/xs3_bcd_sequencer.sv
// Word-level Excess-3 to BCD sequencer. A word is captured on the input
// handshake, converted one digit per cycle (digit 0 first) through a single
// shared converter, then held on the output until the consumer takes it.
module xs3_bcd_sequencer
    import xs3_pkg::*;
#(
    parameter int NDIGITS = 4
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   in_xs3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   out_bcd,
    output logic [NDIGITS-1:0]     out_err,
    output logic                   busy
);

    // Counter is at least one bit wide even for a single-digit word
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIGITS - 1);

    state_t                 state_reg;
    state_t                 state_next;
    logic [CW-1:0]          cnt_reg;
    logic [4*NDIGITS-1:0]   xs3_reg;
    logic                   out_valid_reg;

    logic                   accept;
    logic                   drain;
    logic                   conv_en;
    logic                   last_digit;

    logic [3:0]             xs3_digits [NDIGITS];
    logic [3:0]             conv_xs3;
    logic [3:0]             conv_bcd;
    logic                   conv_err;

    // Handshake qualifiers; clear suppresses both transfers in its cycle
    assign accept     = in_valid && in_ready && !clear;
    assign drain      = out_valid_reg && out_ready && !clear;
    assign last_digit = (cnt_reg == LAST_DIGIT);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clear overrides every other transition
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept)     state_next = CONV;
                CONV:    if (last_digit) state_next = DONE;
                DONE:    if (drain)      state_next = IDLE;
                default:                 state_next = IDLE;
            endcase
        end
    end

    // State-decoded outputs and the conversion enable
    always_comb begin
        in_ready = (state_reg == IDLE);
        busy     = (state_reg == CONV) || (state_reg == DONE);
        conv_en  = (state_reg == CONV);
    end

    // Digit counter: restarts on each transfer and parks on the last digit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clear || accept) begin
            cnt_reg <= '0;
        end else if (conv_en && !last_digit) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Input word capture so later changes on in_xs3 cannot disturb conversion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xs3_reg <= '0;
        end else if (clear) begin
            xs3_reg <= '0;
        end else if (accept) begin
            xs3_reg <= in_xs3;
        end
    end

    // out_valid rises one cycle after entering DONE and drops on the drain edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
        end else if (clear || drain) begin
            out_valid_reg <= 1'b0;
        end else if (state_reg == DONE) begin
            out_valid_reg <= 1'b1;
        end
    end

    assign out_valid = out_valid_reg;

    // Split the captured word into digits for the counter-driven select
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_split
            assign xs3_digits[gi] = xs3_reg[4*gi +: 4];
        end
    endgenerate

    assign conv_xs3 = xs3_digits[cnt_reg];

    xs3_digit_conv u_conv (
        .xs3 (conv_xs3),
        .bcd (conv_bcd),
        .err (conv_err)
    );

    // Per-digit result registers, written only while converting their digit
    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_result
            logic [3:0] bcd_reg;
            logic       err_reg;

            // Capture the shared converter output when the counter selects this digit
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    bcd_reg <= '0;
                    err_reg <= 1'b0;
                end else if (clear) begin
                    bcd_reg <= '0;
                    err_reg <= 1'b0;
                end else if (conv_en && (cnt_reg == CW'(gi))) begin
                    bcd_reg <= conv_bcd;
                    err_reg <= conv_err;
                end
            end

            assign out_bcd[4*gi +: 4] = bcd_reg;
            assign out_err[gi]        = err_reg;
        end
    endgenerate

endmodule
